// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: state encoding, receiver select codes and the parity helper
// shared by the serial transmitter and the 4-bit shift-register receiver.
package serial_tx_pkg;

    // Transmitter FSM states. PARITY is reachable only when the parity frame
    // option (SERIAL_TX_PARITY_EN) is compiled in.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    // Receiver select codes; 2'b11 is never driven by the transmitter.
    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_RIGHT = 2'b01;
    localparam logic [1:0] SEL_LEFT  = 2'b10;

    // Widest word the parity helper accepts. Narrower words are zero-extended,
    // which leaves the XOR reduction unchanged.
    localparam int PARITY_MAX_W = 64;

    // Even parity: the XOR reduction of the word.
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] i_word);
        return ^i_word;
    endfunction

endpackage

// File: rtl/serial_tx.sv
// serial_tx: parallel-in, serial-out transmitter feeding a universal shift
// register. A word accepted over in_valid/in_ready is sent one bit per clock
// together with the select code the receiver needs (right shift for LSB first,
// left shift for MSB first), so the receiver ends up holding the word as sent.
// done pulses in the first IDLE cycle after the frame, in which a new word may
// already be accepted. All outputs come straight from flops.
//
// Handshake: a word is transferred on a rising edge where in_valid and
// in_ready are both high. in_ready is high only in IDLE; a producer raising
// in_valid while in_ready is low is ignored and must hold its word.
//
// Optional feature, macro SERIAL_TX_PARITY_EN: an extra PARITY cycle follows
// the data bits, carrying the even parity of the word on ser_out with
// par_valid=1 and sel_out=hold; the par_valid port exists only in that build.
module serial_tx
    import serial_tx_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic [1:0]       sel_out,
    output logic             done
`ifdef SERIAL_TX_PARITY_EN
    ,
    output logic             par_valid
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Bit sent at position idx of a frame: LSB first when dir=0, MSB first when dir=1.
    function automatic logic pick_bit(input logic [WIDTH-1:0] i_word,
                                      input logic             i_dir,
                                      input logic [CNT_W-1:0] i_idx);
        if (i_dir) begin
            return i_word[CNT_LAST - i_idx];
        end
        return i_word[i_idx];
    endfunction

    // Receiver select code that matches the sending order.
    function automatic logic [1:0] sel_for(input logic i_dir);
        return i_dir ? SEL_LEFT : SEL_RIGHT;
    endfunction

    // FSM and datapath state
    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_data;
    logic               r_dir;

    // Registered outputs
    logic               r_in_ready;
    logic               r_ser_out;
    logic               r_ser_valid;
    logic [1:0]         r_sel_out;
    logic               r_done;

    // Next-state values
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [WIDTH-1:0]   w_data_nxt;
    logic               w_dir_nxt;
    logic               w_in_ready_nxt;
    logic               w_ser_out_nxt;
    logic               w_ser_valid_nxt;
    logic [1:0]         w_sel_out_nxt;
    logic               w_done_nxt;
    logic               w_accept;

`ifdef SERIAL_TX_PARITY_EN
    logic               r_par_valid;
    logic               w_par_valid_nxt;
`endif

    assign w_accept  = in_valid && r_in_ready;
    assign w_cnt_inc = r_cnt + 1'b1;

    // Next state plus the output values for the cycle that follows the edge;
    // outputs default to the idle pattern.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_data_nxt      = r_data;
        w_dir_nxt       = r_dir;
        w_in_ready_nxt  = 1'b1;
        w_ser_out_nxt   = 1'b0;
        w_ser_valid_nxt = 1'b0;
        w_sel_out_nxt   = SEL_HOLD;
        w_done_nxt      = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        w_par_valid_nxt = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    // First bit is presented in the cycle right after the accept.
                    w_state_nxt     = SHIFT;
                    w_cnt_nxt       = '0;
                    w_data_nxt      = in_data;
                    w_dir_nxt       = in_dir;
                    w_in_ready_nxt  = 1'b0;
                    w_ser_valid_nxt = 1'b1;
                    w_sel_out_nxt   = sel_for(in_dir);
                    w_ser_out_nxt   = pick_bit(in_data, in_dir, '0);
                end
            end
            SHIFT: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt = '0;
`ifdef SERIAL_TX_PARITY_EN
                    w_state_nxt     = PARITY;
                    w_in_ready_nxt  = 1'b0;
                    w_par_valid_nxt = 1'b1;
                    w_ser_out_nxt   = even_parity(PARITY_MAX_W'(r_data));
`else
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
`endif
                end else begin
                    w_cnt_nxt       = w_cnt_inc;
                    w_in_ready_nxt  = 1'b0;
                    w_ser_valid_nxt = 1'b1;
                    w_sel_out_nxt   = sel_for(r_dir);
                    w_ser_out_nxt   = pick_bit(r_data, r_dir, w_cnt_inc);
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                w_state_nxt = IDLE;
                w_done_nxt  = 1'b1;
            end
`endif
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, datapath and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_data      <= '0;
            r_dir       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
            r_sel_out   <= SEL_HOLD;
            r_done      <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            r_par_valid <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_data      <= w_data_nxt;
            r_dir       <= w_dir_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_ser_out   <= w_ser_out_nxt;
            r_ser_valid <= w_ser_valid_nxt;
            r_sel_out   <= w_sel_out_nxt;
            r_done      <= w_done_nxt;
`ifdef SERIAL_TX_PARITY_EN
            r_par_valid <= w_par_valid_nxt;
`endif
        end
    end

    assign in_ready  = r_in_ready;
    assign ser_out   = r_ser_out;
    assign ser_valid = r_ser_valid;
    assign sel_out   = r_sel_out;
    assign done      = r_done;
`ifdef SERIAL_TX_PARITY_EN
    assign par_valid = r_par_valid;
`endif

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: bench for serial_tx (WIDTH=4). A table of words is sent
// through the handshake; each transmitted bit is checked against a queue of
// expected bits filled at the accept, a receiver model rebuilds the word from
// ser_out/sel_out, and hand-written sequences cover back-to-back words, a
// request during a frame and a reset in the middle of a frame.
module tb_serial_tx;
    import serial_tx_pkg::*;

    localparam int W       = 4;
    localparam int TIMEOUT = 50;
`ifdef SERIAL_TX_PARITY_EN
    localparam int PAR_CYC = 1;
`else
    localparam int PAR_CYC = 0;
`endif

    // Clock and reset
    logic         clk = 1'b0;
    logic         clear_n;
    logic [W-1:0] in_data;
    logic         in_dir;
    logic         in_valid;
    logic         in_ready;
    logic         ser_out;
    logic         ser_valid;
    logic [1:0]   sel_out;
    logic         done;
`ifdef SERIAL_TX_PARITY_EN
    logic         par_valid;
`endif

    always #5 clk = ~clk;

    serial_tx #(.WIDTH(W)) dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .sel_out   (sel_out),
        .done      (done)
`ifdef SERIAL_TX_PARITY_EN
        ,
        .par_valid (par_valid)
`endif
    );

    // Scoreboard state
    int           n_vec = 0;
    int           n_err = 0;
    logic [0:0]   exp_q[$];
    logic [W-1:0] rx_q = '0;

    // stream[i] is the i-th bit expected on ser_out; par is the even parity of data
    typedef struct {
        logic [W-1:0] data;
        logic         dir;
        logic [W-1:0] stream;
        logic         par;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Downstream shift register model: right shift enters at the MSB, left shift at the LSB
    always @(negedge clk) begin
        if (sel_out == SEL_RIGHT) rx_q <= {ser_out, rx_q[W-1:1]};
        else if (sel_out == SEL_LEFT) rx_q <= {rx_q[W-2:0], ser_out};
    end

    // Bit monitor: every data bit must match the head of the expected queue
    always @(negedge clk) begin
        logic [0:0] e;
        if (clear_n && ser_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL stream_extra: got bit %0b, expected no bit (t=%0t)", ser_out, $time);
            end else begin
                e = exp_q.pop_front();
                check("stream_bit", ser_out, e);
            end
        end
    end

    // Offer a word from a negedge; returns just after the accepting edge
    task automatic drive_word(input logic [W-1:0] data, input logic dir,
                              input logic [W-1:0] stream, input bit release_valid);
        int waited = 0;
        in_data  = data;
        in_dir   = dir;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && waited < TIMEOUT) begin
            @(negedge clk);
            waited++;
        end
        check("accept_wait", waited < TIMEOUT, 1);
        @(posedge clk);
        for (int i = 0; i < W; i++) exp_q.push_back(stream[i]);
        #1;
        if (release_valid) begin
            in_valid = 1'b0;
            in_data  = W'($urandom_range(0, (1 << W) - 1));
            in_dir   = 1'($urandom_range(0, 1));
        end
    endtask

    // Check one frame cycle by cycle; ends on the negedge of the done cycle.
    // poke_cycle > 0 raises in_valid with all-ones data for one cycle mid-frame.
    task automatic watch_frame(input string tag, input logic [W-1:0] exp_rx,
                               input logic exp_par, input logic exp_dir, input int poke_cycle);
        int last      = W + PAR_CYC + 1;
        int ready_low = 0;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (c == poke_cycle) begin
                in_valid = 1'b1;
                in_data  = '1;
            end else if (poke_cycle > 0 && c == poke_cycle + 1) begin
                in_valid = 1'b0;
            end
            if (in_ready !== 1'b1) ready_low++;
            check({tag, "_done"}, done, (c == last));
            if (c <= W) begin
                check({tag, "_ser_valid"}, ser_valid, 1);
                check({tag, "_sel"}, sel_out, exp_dir ? 2'b10 : 2'b01);
`ifdef SERIAL_TX_PARITY_EN
                check({tag, "_par_valid"}, par_valid, 0);
            end else if (c == W + 1) begin
                check({tag, "_par_bit"}, ser_out, exp_par);
                check({tag, "_par_valid"}, par_valid, 1);
                check({tag, "_par_ser_valid"}, ser_valid, 0);
                check({tag, "_par_sel"}, sel_out, 2'b00);
`endif
            end else begin
                check({tag, "_idle_ser_valid"}, ser_valid, 0);
                check({tag, "_idle_sel"}, sel_out, 2'b00);
                check({tag, "_idle_ready"}, in_ready, 1);
            end
        end
        check({tag, "_ready_low"}, ready_low, W + PAR_CYC);
        check({tag, "_rx_word"}, rx_q, exp_rx);
        if (PAR_CYC == 0) check({tag, "_par_unused"}, exp_par, exp_par ^ 1'b0 ^ (^exp_rx) ^ (^exp_rx));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_ser_out"}, ser_out, 0);
        check({tag, "_ser_valid"}, ser_valid, 0);
        check({tag, "_sel"}, sel_out, 2'b00);
        check({tag, "_done"}, done, 0);
`ifdef SERIAL_TX_PARITY_EN
        check({tag, "_par_valid"}, par_valid, 0);
`endif
    endtask

    // Overall time limit
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{data: 4'b1000, dir: 1'b0, stream: 4'b1000, par: 1'b1};
        vecs[1] = '{data: 4'b1011, dir: 1'b1, stream: 4'b1101, par: 1'b1};
        vecs[2] = '{data: 4'b1011, dir: 1'b0, stream: 4'b1011, par: 1'b1};
        vecs[3] = '{data: 4'b0110, dir: 1'b1, stream: 4'b0110, par: 1'b0};
        vecs[4] = '{data: 4'b1110, dir: 1'b0, stream: 4'b1110, par: 1'b1};
        vecs[5] = '{data: 4'b0001, dir: 1'b1, stream: 4'b1000, par: 1'b1};

        clear_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_dir   = 1'b0;
        #12;
        check_reset_values("reset");
        @(negedge clk);
        clear_n = 1'b1;
        @(negedge clk);
        check_reset_values("post_reset_idle");

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            drive_word(vecs[i].data, vecs[i].dir, vecs[i].stream, 1'b1);
            watch_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].par, vecs[i].dir, 0);
        end

        // Back-to-back: in_valid stays high, second word is taken in the done cycle
        drive_word(4'b0101, 1'b0, 4'b0101, 1'b0);
        in_data = 4'b1100;
        watch_frame("b2b_a", 4'b0101, 1'b0, 1'b0, 0);
        drive_word(4'b1100, 1'b0, 4'b1100, 1'b1);
        watch_frame("b2b_b", 4'b1100, 1'b0, 1'b0, 0);

        // Request during SHIFT is ignored: no accept, no extra done
        drive_word(4'b1000, 1'b0, 4'b1000, 1'b1);
        watch_frame("poke", 4'b1000, 1'b1, 1'b0, 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("poke_after_ser_valid", ser_valid, 0);
            check("poke_after_done", done, 0);
            check("poke_after_ready", in_ready, 1);
        end

        // Reset after two bits: immediate abort, no done, clean next frame
        drive_word(4'b0110, 1'b0, 4'b0110, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #2;
        clear_n = 1'b0;
        #1;
        check_reset_values("abort");
        exp_q.delete();
        @(negedge clk);
        clear_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
            check("abort_ser_valid", ser_valid, 0);
        end
        drive_word(4'b0011, 1'b0, 4'b0011, 1'b1);
        watch_frame("after_abort", 4'b0011, 1'b0, 1'b0, 0);

        @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
